serial_add_ctrl: RTL and testbench

Sequencer for the bit-serial adder datapath (x, y in; z out; internal carry flop cleared by its reset). Accepts two parallel WIDTH-bit operands over a valid/ready handshake and clears the adder carry. Streams the operands LSB-first into the adder, then runs one flush cycle to recover the carry-out. Collects the serial sum into a WIDTH+1-bit parallel result, held until the consumer accepts it.

---
 rtl/serial_add_ctrl.sv | 170 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencer for a bit-serial adder.
// Accepts an operand pair, clears the adder carry, streams both operands
// LSB-first, runs one flush cycle to pick up the carry-out, and holds the
// WIDTH+1-bit result until the consumer takes it.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             sa_clr,
  output logic             sa_x,
  output logic             sa_y,
  input  logic             sa_z
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter value seen on the last SHIFT cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // One-position shifted copies of the operand and result registers.
  // Operands drain toward bit 0 with zero fill; the result fills from the
  // top with the adder's sum bit, so bit k ends up at index k.
  logic [WIDTH-1:0] a_shr;
  logic [WIDTH-1:0] b_shr;
  logic [WIDTH-1:0] res_shr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign a_shr[gi]   = 1'b0;
        assign b_shr[gi]   = 1'b0;
        assign res_shr[gi] = sa_z;
      end else begin : g_mid
        assign a_shr[gi]   = a_sh_q[gi+1];
        assign b_shr[gi]   = b_sh_q[gi+1];
        assign res_shr[gi] = res_q[gi+1];
      end
    end
  endgenerate

  // Abort only matters while an operation is actually running.
  logic abort_hit;
  assign abort_hit = abort && ((state_q == S_CLR) || (state_q == S_SHIFT) ||
                               (state_q == S_FLUSH));

  // Next-state, datapath updates and all handshake/adder outputs.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    sa_clr    = !rst;
    sa_x      = 1'b0;
    sa_y      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = rst;
        if (in_valid) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_CLR;
        end
      end

      S_CLR: begin
        busy    = 1'b1;
        sa_clr  = 1'b1;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        busy   = 1'b1;
        sa_x   = a_sh_q[0];
        sa_y   = b_sh_q[0];
        a_sh_d = a_shr;
        b_sh_d = b_shr;
        res_d  = res_shr;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // Operands are exhausted; the adder's sum bit is now the carry-out.
        busy    = 1'b1;
        sum_d   = {sa_z, res_q};
        state_d = S_DONE;
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over every in-flight transition, including the terminal
    // count; the held result and working registers are left untouched.
    if (abort_hit) begin
      state_d = S_IDLE;
      sa_clr  = 1'b1;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench with a bit-serial adder model on the
// sa_* side and a scoreboard queue checked by an independent monitor.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;
  logic             sa_clr;
  logic             sa_x;
  logic             sa_y;
  logic             sa_z;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [WIDTH:0] exp_sum;
    int             acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  serial_add_ctrl #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy),
    .sa_clr    (sa_clr),
    .sa_x      (sa_x),
    .sa_y      (sa_y),
    .sa_z      (sa_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial full adder with a carry flop cleared by sa_clr.
  logic carry_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        carry_q <= 1'b0;
    else if (sa_clr) carry_q <= 1'b0;
    else             carry_q <= (sa_x & sa_y) | (sa_x & carry_q) | (sa_y & carry_q);
  end
  assign sa_z = sa_x ^ sa_y ^ carry_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each new result compare against the scoreboard head,
  // including latency from the accept edge.
  initial begin : monitor
    logic ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        if (sb_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_result: got sum=0x%0h expected no result", sum);
        end else begin
          e = sb_q.pop_front();
          chk("result_sum", 32'(sum), 32'(e.exp_sum));
          chk("result_latency", 32'(cyc - e.acc_cyc), 32'(WIDTH + 2));
          $display("[TB] result sum=0x%03h latency=%0d", sum, cyc - e.acc_cyc);
        end
      end
      ov_prev = out_valid;
    end
  end

  // Present an operand pair and wait for the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] exp, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("[TB] accept a=0x%02h b=0x%02h", a, b);
    if (push) begin
      e.exp_sum = exp;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  // Full operation with out_ready=1, checking serial bits and the flush cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] exp);
    send(a, b, exp, 1'b1);
    chk("clr_cycle_sa_clr", 32'(sa_clr), 32'd1);
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      chk("shift_sa_x", 32'(sa_x), 32'(a[i]));
      chk("shift_sa_y", 32'(sa_y), 32'(b[i]));
      tick();
    end
    chk("flush_sa_x", 32'(sa_x), 32'd0);
    chk("flush_sa_y", 32'(sa_y), 32'd0);
    chk("flush_carry", 32'(sa_z), 32'(exp[WIDTH]));
    chk("flush_busy", 32'(busy), 32'd1);
    tick();
    chk("done_out_valid", 32'(out_valid), 32'd1);
    tick();
  endtask

  initial begin : stim
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    // Reset values.
    #2;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sa_clr", 32'(sa_clr), 32'd1);
    chk("rst_sa_x", 32'(sa_x), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_sa_clr", 32'(sa_clr), 32'd0);

    // Basic sums, including carry-out cases.
    run_op(8'h5A, 8'h3C, 9'h096);
    run_op(8'hFF, 8'h01, 9'h100);
    run_op(8'hFF, 8'hFF, 9'h1FE);

    // Back-to-back with the consumer stalling in DONE.
    out_ready = 1'b0;
    send(8'h5A, 8'h3C, 9'h096, 1'b1);
    wait_done();
    in_a     = 8'hFF;
    in_b     = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h096);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_sum_held", 32'(sum), 32'h096);
    send(8'hFF, 8'h01, 9'h100, 1'b1);
    wait_done();
    tick();

    // Abort on the 4th SHIFT cycle.
    send(8'hFF, 8'hFF, 9'h1FE, 1'b0);
    tick();
    tick();
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("abort_sa_clr", 32'(sa_clr), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    #1;
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum_kept", 32'(sum), 32'h100);
    $display("[TB] abort in SHIFT");
    run_op(8'h01, 8'h01, 9'h002);

    // Asynchronous reset mid-SHIFT, between clock edges.
    send(8'hFF, 8'h01, 9'h100, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sa_clr", 32'(sa_clr), 32'd1);
    chk("arst_sa_x", 32'(sa_x), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    $display("[TB] async reset mid-SHIFT");
    tick();
    rst = 1'b1;
    #1;
    run_op(8'h80, 8'h80, 9'h100);

    // New operands offered during SHIFT must be ignored.
    send(8'h33, 8'h11, 9'h044, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_a     = 8'hFF;
      in_b     = 8'hFF;
      chk("shift_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_done();
    tick();
    tick();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
